// File: rtl/hud_font_pkg.sv
// Glyph codes, text box geometry and conversion FSM states shared by the HUD score text block.
package hud_font_pkg;

  localparam logic [3:0] GLY_0     = 4'd0;
  localparam logic [3:0] GLY_1     = 4'd1;
  localparam logic [3:0] GLY_2     = 4'd2;
  localparam logic [3:0] GLY_3     = 4'd3;
  localparam logic [3:0] GLY_4     = 4'd4;
  localparam logic [3:0] GLY_5     = 4'd5;
  localparam logic [3:0] GLY_6     = 4'd6;
  localparam logic [3:0] GLY_7     = 4'd7;
  localparam logic [3:0] GLY_8     = 4'd8;
  localparam logic [3:0] GLY_9     = 4'd9;
  localparam logic [3:0] GLY_COLON = 4'd10;
  localparam logic [3:0] GLY_S     = 4'd11;
  localparam logic [3:0] GLY_C     = 4'd12;
  localparam logic [3:0] GLY_O     = 4'd13;
  localparam logic [3:0] GLY_R     = 4'd14;
  localparam logic [3:0] GLY_E     = 4'd15;

  localparam int unsigned TEXT_W  = 80;
  localparam int unsigned TEXT_H  = 16;
  localparam int unsigned BCD_MAX = 9999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the left shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (res[4*i +: 4] >= 4'd5) res[4*i +: 4] = res[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, saturating at 9999.
module bin2bcd_seq
  import hud_font_pkg::*;
#(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(W);

  conv_state_e    state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   bin_sat;
  logic [W+15:0]  step;

  always_comb begin
    bin_sat = (32'(bin) > BCD_MAX) ? W'(BCD_MAX) : bin;
    step    = {dabble_adjust(bcd_q), sh_q} << 1;
    state_d = state_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = bin_sat;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      // The cycle that finds all W steps done moves on, so busy spans W+2 cycles.
      SHIFT: begin
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end else begin
          bcd_d = step[W+15:W];
          sh_d  = step[W-1:0];
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_text_ctrl.sv
// Draws "SCORE:dddd" from an external glyph ROM; score digits commit only at frame start.
module score_text_ctrl
  import hud_font_pkg::*;
#(
  parameter int unsigned X0         = 16,
  parameter int unsigned Y0         = 8,
  parameter int unsigned SCORE_W    = 14,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  input  logic               frame_start,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         font_addr,
  input  logic [7:0]         font_data,
  output logic               pixel_on,
  output logic               busy
);

  logic               req_q;
  logic [SCORE_W-1:0] req_val_q;
  logic               conv_busy, conv_done, conv_start;
  logic [SCORE_W-1:0] conv_val;
  logic [15:0]        conv_bcd;
  logic [15:0]        shadow_q, disp_q;
  logic               pending_q;

  // A fresh strobe always beats a buffered request.
  assign conv_start = (score_valid | req_q) & ~conv_busy;
  assign conv_val   = score_valid ? score : req_val_q;
  assign busy       = conv_busy;

  bin2bcd_seq #(
    .W (SCORE_W)
  ) u_bin2bcd (
    .clk   (Clk),
    .rst_n (Reset_n),
    .start (conv_start),
    .bin   (conv_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q     <= 1'b0;
      req_val_q <= '0;
    end else if (score_valid && conv_busy) begin
      req_q     <= 1'b1;
      req_val_q <= score;
    end else if (conv_start) begin
      req_q     <= 1'b0;
    end
  end

  // A DONE coinciding with frame_start wins; the commit waits for the next frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
    end else if (conv_done) begin
      shadow_q  <= conv_bcd;
      pending_q <= 1'b1;
    end else if (frame_start && pending_q) begin
      disp_q    <= shadow_q;
      pending_q <= 1'b0;
    end
  end

  logic [9:0] dx, dy;
  logic       in_box, hide, blank3, blank2, blank1;
  logic [3:0] slot, code;
  logic [7:0] addr_d, addr_q;
  logic [2:0] col_d, col_q;
  logic       vis_d, vis_q;
  logic       pix_q;

  always_comb begin
    dx     = DrawX - 10'(X0);
    dy     = DrawY - 10'(Y0);
    in_box = (DrawX >= 10'(X0)) && (dx < 10'(TEXT_W)) &&
             (DrawY >= 10'(Y0)) && (dy < 10'(TEXT_H));
    slot   = dx[6:3];
    blank3 = LEAD_BLANK && (disp_q[15:12] == 4'd0);
    blank2 = blank3 && (disp_q[11:8] == 4'd0);
    blank1 = blank2 && (disp_q[7:4] == 4'd0);
    code   = GLY_0;
    hide   = 1'b0;
    case (slot)
      4'd0: code = GLY_S;
      4'd1: code = GLY_C;
      4'd2: code = GLY_O;
      4'd3: code = GLY_R;
      4'd4: code = GLY_E;
      4'd5: code = GLY_COLON;
      4'd6: begin code = disp_q[15:12]; hide = blank3; end
      4'd7: begin code = disp_q[11:8];  hide = blank2; end
      4'd8: begin code = disp_q[7:4];   hide = blank1; end
      4'd9: code = disp_q[3:0];
      default: code = GLY_0;
    endcase
    addr_d = in_box ? {code, dy[3:0]} : 8'd0;
    col_d  = in_box ? dx[2:0] : 3'd0;
    vis_d  = in_box & ~hide;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q <= '0;
      col_q  <= '0;
      vis_q  <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      vis_q  <= vis_d;
      pix_q  <= vis_q & font_data[3'd7 - col_q];
    end
  end

  assign font_addr = addr_q;
  assign pixel_on  = pix_q;

endmodule
